// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: buffers completed instructions in a 2-entry FIFO and
// retires one per cycle onto the register-file write ports. Commits stop on halt or exception.
module wb_commit_unit #(
    parameter int                  DATA_WID = 64,
    parameter int                  ADDR_WID = 4,
    parameter logic [ADDR_WID-1:0] RNONE    = 4'hF,
    parameter int                  DEPTH    = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_stat,
    input  logic [DATA_WID-1:0] in_valE,
    input  logic [DATA_WID-1:0] in_valM,
    input  logic [ADDR_WID-1:0] in_dstE,
    input  logic [ADDR_WID-1:0] in_dstM,
    input  logic                wb_stall,
    output logic [DATA_WID-1:0] valE,
    output logic [DATA_WID-1:0] valM,
    output logic [ADDR_WID-1:0] destE,
    output logic [ADDR_WID-1:0] destM,
    output logic [2:0]          stat,
    output logic                halted,
    output logic [31:0]         retired
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic [1:0] {RUN, HALT, ERR} state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [DATA_WID-1:0] valE_q, valM_q;
    logic [ADDR_WID-1:0] destE_q, destM_q;
    logic [2:0]          stat_q;
    logic [31:0]         retired_q;

    logic [2:0]          stat_mem [DEPTH];
    logic [DATA_WID-1:0] valE_mem [DEPTH];
    logic [DATA_WID-1:0] valM_mem [DEPTH];
    logic [ADDR_WID-1:0] dstE_mem [DEPTH];
    logic [ADDR_WID-1:0] dstM_mem [DEPTH];

    logic                push, pop;
    logic [2:0]          head_stat;
    logic [ADDR_WID-1:0] head_dstE, head_dstM;

    assign pop       = (state_q == RUN) && (count_q != '0) && !wb_stall;
    assign in_ready  = (state_q == RUN) && ((count_q < CNT_W'(DEPTH)) || pop);
    assign push      = in_valid && in_ready;
    assign head_stat = stat_mem[rd_ptr_q];
    assign head_dstE = dstE_mem[rd_ptr_q];
    assign head_dstM = dstM_mem[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (push) begin
            stat_mem[wr_ptr_q] <= in_stat;
            valE_mem[wr_ptr_q] <= in_valE;
            valM_mem[wr_ptr_q] <= in_valM;
            dstE_mem[wr_ptr_q] <= in_dstE;
            dstM_mem[wr_ptr_q] <= in_dstM;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= RUN;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            valE_q    <= '0;
            valM_q    <= '0;
            destE_q   <= RNONE;
            destM_q   <= RNONE;
            stat_q    <= S_AOK;
            retired_q <= '0;
        end else begin
            destE_q <= RNONE;
            destM_q <= RNONE;
            if (pop && head_stat != S_AOK) begin
                // Any fault or halt flushes the buffer, including a same-cycle push.
                state_q  <= (head_stat == S_HLT) ? HALT : ERR;
                stat_q   <= (head_stat == S_HLT || head_stat == S_ADR) ? head_stat : S_INS;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (pop) begin
                    valE_q    <= valE_mem[rd_ptr_q];
                    valM_q    <= valM_mem[rd_ptr_q];
                    // Same destination on both ports: the memory result wins.
                    destE_q   <= (head_dstE == head_dstM) ? RNONE : head_dstE;
                    destM_q   <= head_dstM;
                    retired_q <= retired_q + 32'd1;
                    rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    assign valE    = valE_q;
    assign valM    = valM_q;
    assign destE   = destE_q;
    assign destM   = destM_q;
    assign stat    = stat_q;
    assign halted  = (state_q != RUN);
    assign retired = retired_q;
endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: hand-computed write-port, status and handshake checks.
module tb_wb_commit_unit;
    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_stat;
    logic [63:0] in_valE, in_valM;
    logic [3:0]  in_dstE, in_dstM;
    logic        wb_stall;
    logic [63:0] valE, valM;
    logic [3:0]  destE, destM;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] retired;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    wb_commit_unit dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_stat(in_stat),
        .in_valE(in_valE), .in_valM(in_valM), .in_dstE(in_dstE), .in_dstM(in_dstM),
        .wb_stall(wb_stall),
        .valE(valE), .valM(valM), .destE(destE), .destM(destM),
        .stat(stat), .halted(halted), .retired(retired)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        in_valid = 1'b1;
        in_stat  = s;
        in_dstE  = de;
        in_valE  = ve;
        in_dstM  = dm;
        in_valM  = vm;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        in_valid = 1'b0;
        step();
        RST = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".destE"}, 64'(destE), 64'hF);
        chk({tag, ".destM"}, 64'(destM), 64'hF);
        chk({tag, ".stat"}, 64'(stat), 64'd1);
        chk({tag, ".halted"}, 64'(halted), 64'd0);
        chk({tag, ".retired"}, 64'(retired), 64'd0);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; wb_stall = 1'b0;
        in_stat = 3'd1; in_valE = '0; in_valM = '0; in_dstE = 4'hF; in_dstM = 4'hF;
        step(); step();
        RST = 1'b0;
        chk_reset("reset");
        chk("reset.valE", valE, 64'd0);
        chk("reset.valM", valM, 64'd0);

        // Single AOK instruction: pushed at one edge, committed at the next.
        drive(3'd1, 4'd2, 64'h10, 4'hF, 64'h0);
        step();
        in_valid = 1'b0;
        chk("single.no_bypass", 64'(destE), 64'hF);
        step();
        chk("single.destE", 64'(destE), 64'd2);
        chk("single.valE", valE, 64'h10);
        chk("single.destM", 64'(destM), 64'hF);
        chk("single.retired", 64'(retired), 64'd1);
        step();
        chk("single.idle_destE", 64'(destE), 64'hF);
        chk("single.hold_valE", valE, 64'h10);

        // Stall fills the FIFO; release pops and pushes in the same cycle.
        wb_stall = 1'b1;
        drive(3'd1, 4'd6, 64'hA1, 4'hF, 64'h0);
        step();
        drive(3'd1, 4'd7, 64'hB2, 4'hF, 64'h0);
        step();
        chk("stall.full_ready", 64'(in_ready), 64'd0);
        drive(3'd1, 4'd8, 64'hC3, 4'hF, 64'h0);
        step();
        chk("stall.still_full", 64'(in_ready), 64'd0);
        chk("stall.no_write", 64'(destE), 64'hF);
        wb_stall = 1'b0;
        #1;
        chk("stall.release_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("stall.first_destE", 64'(destE), 64'd6);
        chk("stall.first_valE", valE, 64'hA1);
        step();
        chk("stall.second_destE", 64'(destE), 64'd7);
        chk("stall.second_valE", valE, 64'hB2);
        step();
        chk("stall.third_destE", 64'(destE), 64'd8);
        chk("stall.third_valE", valE, 64'hC3);
        step();
        chk("stall.drained", 64'(destE), 64'hF);
        chk("stall.retired", 64'(retired), 64'd4);

        // Same destination on both ports: only the M port writes.
        drive(3'd1, 4'd4, 64'h1, 4'd4, 64'h2);
        step();
        in_valid = 1'b0;
        step();
        chk("samedst.destE", 64'(destE), 64'hF);
        chk("samedst.destM", 64'(destM), 64'd4);
        chk("samedst.valM", valM, 64'h2);
        chk("samedst.retired", 64'(retired), 64'd5);
        step();

        // Halt freezes commits and flushes the entry behind it.
        drive(3'd1, 4'd1, 64'h11, 4'hF, 64'h0);
        step();
        drive(3'd2, 4'd3, 64'h33, 4'hF, 64'h0);
        step();
        chk("halt.first_destE", 64'(destE), 64'd1);
        drive(3'd1, 4'd5, 64'h55, 4'hF, 64'h0);
        step();
        in_valid = 1'b0;
        chk("halt.hlt_no_write", 64'(destE), 64'hF);
        chk("halt.stat", 64'(stat), 64'd2);
        chk("halt.halted", 64'(halted), 64'd1);
        for (int i = 0; i < 4; i++) begin
            wb_stall = i[0];
            in_valid = 1'b1;
            step();
            chk($sformatf("halt.frozen_destE[%0d]", i), 64'(destE), 64'hF);
            chk($sformatf("halt.frozen_ready[%0d]", i), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        wb_stall = 1'b0;
        chk("halt.retired", 64'(retired), 64'd6);
        chk("halt.stat_held", 64'(stat), 64'd2);

        // ADR exception then reset recovery.
        do_reset();
        chk_reset("reset2");
        drive(3'd3, 4'd9, 64'h99, 4'hF, 64'h0);
        step();
        in_valid = 1'b0;
        step();
        chk("adr.no_write", 64'(destE), 64'hF);
        chk("adr.stat", 64'(stat), 64'd3);
        chk("adr.halted", 64'(halted), 64'd1);
        chk("adr.ready", 64'(in_ready), 64'd0);
        step();
        do_reset();
        chk_reset("adr_recover");

        // Out-of-range status reports as INS.
        drive(3'd0, 4'd9, 64'h99, 4'hF, 64'h0);
        step();
        in_valid = 1'b0;
        step();
        chk("ins0.stat", 64'(stat), 64'd4);
        chk("ins0.halted", 64'(halted), 64'd1);
        chk("ins0.destE", 64'(destE), 64'hF);
        do_reset();
        drive(3'd6, 4'd9, 64'h99, 4'hF, 64'h0);
        step();
        in_valid = 1'b0;
        step();
        chk("ins6.stat", 64'(stat), 64'd4);
        chk("ins6.retired", 64'(retired), 64'd0);
        do_reset();

        // Reset while the FIFO holds two stalled entries discards them.
        wb_stall = 1'b1;
        drive(3'd1, 4'd10, 64'hAA, 4'd11, 64'hBB);
        step();
        drive(3'd1, 4'd12, 64'hCC, 4'd13, 64'hDD);
        step();
        chk("rstbuf.full", 64'(in_ready), 64'd0);
        do_reset();
        wb_stall = 1'b0;
        chk_reset("rstbuf.reset");
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rstbuf.destE[%0d]", i), 64'(destE), 64'hF);
            chk($sformatf("rstbuf.destM[%0d]", i), 64'(destM), 64'hF);
        end
        chk("rstbuf.retired", 64'(retired), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Writeback/commit stage that sits between the memory stage and the register file's write side.
- Accepts completed instructions (valE, valM, dstE, dstM, stat) through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Retires one entry per cycle onto the register file write ports (valE, valM, destE, destM).
- Tracks processor status and freezes commits on halt or exception.

Parameters:
- DATA_WID, 64, width of register values.
- ADDR_WID, 4, width of register IDs.
- RNONE, 4'hF, register ID meaning "no write".
- DEPTH, 2, FIFO entries; fixed at 2.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  memory stage presents a completed instruction.
- in_ready  output  1  unit can accept this cycle.
- in_stat  input  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- in_valE  input  DATA_WID  ALU result.
- in_valM  input  DATA_WID  memory result.
- in_dstE  input  ADDR_WID  destination for valE.
- in_dstM  input  ADDR_WID  destination for valM.
- wb_stall  input  1  holds the FIFO head; no retire this cycle.
- valE  output  DATA_WID  register file write data E.
- valM  output  DATA_WID  register file write data M.
- destE  output  ADDR_WID  register file write address E; RNONE means no write.
- destM  output  ADDR_WID  register file write address M; RNONE means no write.
- stat  output  3  current processor status.
- halted  output  1  high in the HALT or ERR state.
- retired  output  32  count of AOK instructions committed.

Behaviour:
- Reset (RST high at an edge): FIFO emptied and the state machine goes to RUN. Outputs after reset:
  - destE = destM = RNONE
  - valE = valM = 0
  - stat = 1 (AOK)
  - halted = 0
  - retired = 0
- Reset mid-operation discards buffered entries. No write port is driven on the cycle after reset.
- State machine (RUN, HALT, ERR):
  - RUN: accepts and retires entries.
  - HALT: entered on popping an entry with stat=2.
  - ERR: entered on popping an entry with stat=3 or 4.
  - HALT and ERR are absorbing until RST.
  - Popping an entry with stat=0 or >4 is treated as INS: stat output becomes 4 and the state goes to ERR.
- Accept: in_ready = (state==RUN) && (count<2 || pop). A push occurs when in_valid && in_ready.
  - Push and pop in the same cycle are legal, including when the FIFO is full.
  - When in_ready=0, in_valid is ignored and the inputs are not sampled.
- Pop: occurs when state==RUN && count>0 && !wb_stall, and always removes the head entry.
- There is no same-cycle bypass. An entry pushed at edge N can pop no earlier than edge N+1.
- Write ports are registered and updated every edge:
  - On a pop of an AOK entry: valE/valM/destE/destM take the head entry's values.
  - With no pop: destE = destM = RNONE, and valE/valM hold their previous values.
  - On a pop of a non-AOK entry: destE = destM = RNONE, the write is suppressed, and stat takes the entry's status.
  - Latency: an entry that is head at edge N appears on the write ports during cycle N..N+1, and the register file commits it at edge N+1.
- Same destination: if the head has dstE==dstM and dstE!=RNONE, destE is driven as RNONE, so valM wins.
- On entering HALT or ERR, the remaining FIFO entries are flushed and never written. in_ready stays 0.
- retired increments by 1 on each AOK pop and wraps modulo 2^32. Non-AOK pops do not increment it.
- wb_stall has no effect in HALT or ERR, where nothing retires anyway.

Test Plan:
- Single AOK push {dstE=2, valE=0x10, dstM=RNONE}, wb_stall=0:
  - The next cycle shows destE=2, valE=0x10, destM=RNONE.
  - The following cycle shows destE=RNONE.
  - retired=1.
- wb_stall=1 while pushing 3 entries:
  - The first two are accepted and in_ready drops to 0 with count=2.
  - Releasing wb_stall retires them in order on consecutive cycles, and in_ready rises in the first release cycle (push and pop together).
- Push {dstE=4, dstM=4, valE=0x1, valM=0x2}: the write ports show destE=RNONE, destM=4, valM=0x2.
- Push AOK{dstE=1}, then HLT{dstE=3}, then AOK{dstE=5}:
  - Only register 1 is written.
  - stat=2, halted=1, and in_ready=0 forever after.
  - The third entry is never written and retired=1.
- Push an entry with stat=3 (ADR): no write occurs, stat=3, the state goes to ERR, then asserting RST for one cycle gives stat=1, halted=0, retired=0, and in_ready=1.
- Assert RST while 2 entries are buffered with wb_stall=1: after reset, destE/destM stay RNONE for all subsequent cycles with in_valid=0.
